s2_mux_pipe: RTL and testbench
==============================

// Module: s2_mux_pipe
// PURPOSE
//  Parametrised successor of the single-stage S2 select cell.
//  - Selects one of 2**SEL_W N-bit data words. Each select bit is the AND or OR of an a/b input pair.
//  - Carries the result through a DEPTH-stage elastic pipeline with valid/ready handshakes.
//  - Keeps a wrapping count of delivered words.
//  Sits between operand sources and a consumer that may stall.
// PARAMETERS
//  N         1      data width per input word
//  SEL_W     2      select bits; number of data inputs = 2**SEL_W
//  GATE_MODE 2'b10  SEL_W-bit mask: bit i=1 -> sel[i]=a[i]|b[i]; bit i=0 -> sel[i]=a[i]&b[i]
//  DEPTH     2      pipeline stages, >=1
//  CNT_W     8      width of the delivered-word counter
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             asynchronous reset, active-high
//  clr        in   1             synchronous clear, active-high
//  d          in   N*2**SEL_W    flattened data; word k = d[k*N +: N]
//  a, b       in   SEL_W         select operand pairs
//  in_valid   in   1             input word valid
//  in_ready   out  1             stage 0 can accept
//  out        out  N             selected word, last stage
//  out_sel    out  SEL_W         select value that produced out
//  out_valid  out  1             last stage holds valid word
//  out_ready  in   1             consumer accepts
//  xfer_cnt   out  CNT_W         count of output handshakes, wraps
// BEHAVIOUR
//  - Select logic: sel = per-bit gate(a,b) per GATE_MODE. Word d[sel*N +: N] and sel are captured
//    into stage 0 on an input handshake (in_valid & in_ready).
//  - Stage k has regs {v_k, data_k, sel_k}.
//    - ready_k = !v_k | ready_{k+1}; ready_DEPTH = out_ready.
//    - Stage k loads from stage k-1 when ready_k. v_k <= v_{k-1}, and v_0 <= in_valid.
//    - A stage with ready_k=0 holds all of its regs.
//  - in_ready = ready_0 & !clr. This is combinational from out_ready; no registered skid buffer.
//  - out/out_sel/out_valid = last-stage regs.
//  - Latency: DEPTH cycles from input handshake to out_valid when never stalled.
//  - Throughput: 1 word/cycle.
//  - Ordering: strictly FIFO. No word is dropped or duplicated.
//  - Stall: out_valid=1 & out_ready=0 -> out/out_sel held stable. Bubbles compress upstream.
//    Pipe full -> in_ready=0 exactly DEPTH accepted words after the stall starts from an empty pipe.
//  - Simultaneous out and in handshake on a full pipe: both complete the same cycle; pipe stays full, no bubble.
//  - xfer_cnt increments on each out_valid & out_ready. It wraps from 2**CNT_W-1 to 0.
//  - clr (sync) has priority over every transfer that cycle.
//    - Next edge: all v_k, data_k, sel_k and xfer_cnt go to 0.
//    - Words in flight are discarded.
//    - The output handshake in that cycle does not count.
//  - rst (async): immediately forces all v_k, data_k, sel_k and xfer_cnt to 0, i.e. out=0, out_sel=0,
//    out_valid=0, xfer_cnt=0. Mid-stream rst discards in-flight words.
//  - Reset values: out=0, out_sel=0, out_valid=0, xfer_cnt=0. in_ready=1 after reset (empty pipe, clr low).
// TESTING (N=4, SEL_W=2, GATE_MODE=2'b10, DEPTH=2, CNT_W=3 unless noted)
//  1. d={4'hD,4'hC,4'hB,4'hA}, a=2'b01, b=2'b01, one valid, out_ready=1
//     -> sel=2'b01; 2 cycles later out=4'hB, out_sel=1, out_valid=1 for 1 cycle.
//     Then a=2'b10, b=2'b00 -> out=4'hC, out_sel=2.
//  2. out_ready=0, offer words 1,2,3
//     -> words 1,2 accepted, then in_ready=0, out=1 held stable.
//     Release out_ready -> out delivers 1,2,3 in order on consecutive cycles.
//  3. Full pipe, in_valid=1 and out_ready=1 for 6 cycles
//     -> 6 in-handshakes and 6 out-handshakes, out_valid never drops.
//  4. Pipe holding 2 words, clr=1 for one cycle with in_valid=1, out_ready=1
//     -> in_ready=0 that cycle; next cycle out_valid=0, xfer_cnt=0; incoming word not captured.
//  5. Continuous streaming, 9 output handshakes -> xfer_cnt reads 1 (wrap at 8).
//  6. rst asserted between clock edges with 2 words in flight
//     -> out_valid, out, out_sel, xfer_cnt at 0 before next edge.
//     After rst release, a new word emerges after 2 cycles.

Source files
------------

// File: rtl/s2_mux_pipe.sv
// Gated-select word mux feeding a DEPTH-stage elastic valid/ready pipeline,
// with a wrapping count of words delivered to the consumer.
module s2_mux_pipe #(
  parameter int                   N         = 1,
  parameter int                   SEL_W     = 2,
  parameter logic [SEL_W-1:0]     GATE_MODE = SEL_W'(2'b10),
  parameter int                   DEPTH     = 2,
  parameter int                   CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [N*(2**SEL_W)-1:0] d,
  input  logic [SEL_W-1:0]        a,
  input  logic [SEL_W-1:0]        b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N-1:0]            out,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        xfer_cnt
);

  logic [DEPTH-1:0]                v_q, v_d;
  logic [DEPTH-1:0][N-1:0]         data_q, data_d;
  logic [DEPTH-1:0][SEL_W-1:0]     sel_q, sel_d;
  logic [CNT_W-1:0]                xfer_cnt_q, xfer_cnt_d;

  logic [SEL_W-1:0]                gate_sel;
  logic [N-1:0]                    gate_word;
  logic [DEPTH:0]                  ready;

  // Each select bit is independently an AND or an OR of its operand pair.
  always_comb begin
    for (int i = 0; i < SEL_W; i++) begin
      gate_sel[i] = GATE_MODE[i] ? (a[i] | b[i]) : (a[i] & b[i]);
    end
    gate_word = d[int'(gate_sel)*N +: N];
  end

  // Ready ripples back from the consumer, so a bubble anywhere lets the
  // stages behind it advance even while the output is stalled.
  // NOTE: combinational logic uses blocking '=' so each line sees the value
  // computed just above it; every output is assigned a default first so no
  // path through the block leaves a latch behind.
  always_comb begin
    ready[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready[k] = !v_q[k] | ready[k+1];
    end

    v_d        = v_q;
    data_d     = data_q;
    sel_d      = sel_q;
    xfer_cnt_d = xfer_cnt_q;

    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (ready[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          data_d[k] = data_q[k-1];
          sel_d[k]  = sel_q[k-1];
        end
      end
    end

    if (ready[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = gate_word;
        sel_d[0]  = gate_sel;
      end
    end

    if (v_q[DEPTH-1] && out_ready) begin
      xfer_cnt_d = xfer_cnt_q + 1'b1;
    end

    // Clear wins over any transfer, including the output handshake.
    if (clr) begin
      v_d        = '0;
      data_d     = '0;
      sel_d      = '0;
      xfer_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all stages update from
  // the same pre-edge values; data and select regs are reset along with the
  // valids because out/out_sel must read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q        <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      xfer_cnt_q <= '0;
    end else begin
      v_q        <= v_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign in_ready  = ready[0] & !clr;
  assign out       = data_q[DEPTH-1];
  assign out_sel   = sel_q[DEPTH-1];
  assign out_valid = v_q[DEPTH-1];
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_s2_mux_pipe.sv
// Directed bench for s2_mux_pipe: a scoreboard queue records every accepted
// word and is compared, in order, against each output handshake.
module tb_s2_mux_pipe;

  localparam int N     = 4;
  localparam int SEL_W = 2;
  localparam int DEPTH = 2;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [N-1:0]     data;
    logic [SEL_W-1:0] sel;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    clr;
  logic [N*(2**SEL_W)-1:0] d;
  logic [SEL_W-1:0]        a, b;
  logic                    in_valid;
  logic                    in_ready;
  logic [N-1:0]            out;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic [CNT_W-1:0]        xfer_cnt;

  exp_t             q[$];
  logic [CNT_W-1:0] exp_cnt;
  logic             last_in_hs, last_out_hs;
  int               passed = 0;
  int               total  = 0;

  s2_mux_pipe #(
    .N(N), .SEL_W(SEL_W), .GATE_MODE(2'b10), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .d(d), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bit 1 is an OR gate, bit 0 an AND gate for the 2'b10 mode under test.
  function automatic logic [SEL_W-1:0] model_sel(input logic [SEL_W-1:0] ai, input logic [SEL_W-1:0] bi);
    return {ai[1] | bi[1], ai[0] & bi[0]};
  endfunction

  // One clock: sample handshakes before the edge, update the scoreboard after.
  task automatic step();
    logic             in_hs, out_hs, clr_s;
    logic [N-1:0]     o;
    logic [SEL_W-1:0] os;
    exp_t             e, x;
    #1;
    in_hs  = in_valid & in_ready;
    out_hs = out_valid & out_ready;
    clr_s  = clr;
    e.sel  = model_sel(a, b);
    e.data = d[int'(e.sel)*N +: N];
    o      = out;
    os     = out_sel;
    @(posedge clk);
    #1;
    last_in_hs  = in_hs && !clr_s;
    last_out_hs = out_hs && !clr_s;
    if (clr_s) begin
      q.delete();
      exp_cnt = '0;
    end else begin
      if (out_hs) begin
        check("sb_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          x = q.pop_front();
          check("out_data", 32'(o), 32'(x.data));
          check("out_sel", 32'(os), 32'(x.sel));
        end
        exp_cnt = exp_cnt + 1'b1;
      end
      if (in_hs) q.push_back(e);
    end
    check("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    check("drain_queue", q.size(), 0);
    check("drain_empty", 32'(out_valid), 0);
  endtask

  task automatic rand_in();
    d = $urandom;
    a = SEL_W'($urandom_range(0, 3));
    b = SEL_W'($urandom_range(0, 3));
  endtask

  initial begin
    int outs;
    int word;

    rst = 1'b1; clr = 1'b0; d = '0; a = '0; b = '0;
    in_valid = 1'b0; out_ready = 1'b0; exp_cnt = '0;
    last_in_hs = 1'b0; last_out_hs = 1'b0;

    #12;
    check("rst_out", 32'(out), 0);
    check("rst_out_sel", 32'(out_sel), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    #1 rst = 1'b0;

    // 1: single words through an unstalled pipe, two-cycle latency.
    d = 16'hDCBA; a = 2'b01; b = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_lat_early", 32'(out_valid), 0);
    step();
    check("t1_valid", 32'(out_valid), 1);
    check("t1_out", 32'(out), 32'hB);
    check("t1_sel", 32'(out_sel), 1);
    step();
    check("t1_one_cycle", 32'(out_valid), 0);
    a = 2'b10; b = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("t1b_out", 32'(out), 32'hC);
    check("t1b_sel", 32'(out_sel), 2);
    drain();

    // 2: stalled consumer, words 1,2,3 with select 0.
    a = 2'b00; b = 2'b00; out_ready = 1'b0; word = 1;
    for (int i = 0; i < 6 && word <= 2; i++) begin
      d = 16'(word); in_valid = 1'b1;
      step();
      if (last_in_hs) word++;
    end
    check("t2_accepted", word, 3);
    d = 16'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_in_ready_low", 32'(in_ready), 0);
      check("t2_hold_valid", 32'(out_valid), 1);
      check("t2_hold_out", 32'(out), 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = (word <= 3);
      step();
      if (last_in_hs) word++;
      check("t2_consecutive", 32'(last_out_hs), 1);
    end
    drain();

    // 3: full pipe with simultaneous in/out handshakes.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_in();
      step();
      check("t3_fill", 32'(last_in_hs), 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_in();
      step();
      check("t3_in_hs", 32'(last_in_hs), 1);
      check("t3_out_hs", 32'(last_out_hs), 1);
      check("t3_valid", 32'(out_valid), 1);
    end
    drain();

    // 4: synchronous clear with two words in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_in();
      step();
    end
    clr = 1'b1; out_ready = 1'b1; rand_in();
    #1;
    check("t4_in_ready_clr", 32'(in_ready), 0);
    step();
    clr = 1'b0; in_valid = 1'b0;
    check("t4_valid_cleared", 32'(out_valid), 0);
    check("t4_cnt_cleared", 32'(xfer_cnt), 0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t4_not_captured", 32'(out_valid), 0);
    end

    // 5: counter wraps at 8.
    outs = 0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 30 && outs < 9; i++) begin
      rand_in();
      step();
      if (last_out_hs) outs++;
    end
    check("t5_outs", outs, 9);
    check("t5_wrap", 32'(xfer_cnt), 1);
    drain();

    // 6: asynchronous reset between edges with two words in flight.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_in();
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_valid", 32'(out_valid), 0);
    check("t6_out", 32'(out), 0);
    check("t6_sel", 32'(out_sel), 0);
    check("t6_cnt", 32'(xfer_cnt), 0);
    q.delete();
    exp_cnt = '0;
    #2 rst = 1'b0;
    rand_in(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t6_lat_early", 32'(out_valid), 0);
    step();
    check("t6_new_word", 32'(out_valid), 1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
